clk_rate_monitor: RTL

- Checks a divided clock produced by the clock divider, such as the serial or encoder clock, after that clock has crossed into the local_clk domain.
- Samples the monitored clock as data and measures its period in local_clk cycles.
- Compares the measured period with the expected period for the current gen_speed.
- Reports lock, rate errors and stuck-clock conditions to the link-training FSM.

---
 rtl/clk_rate_monitor.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/clk_rate_monitor.sv
// Clock-rate monitor: measures the period of a divided clock sampled in the local_clk domain
// and reports lock, rate errors and stuck-clock timeouts to the link-training FSM.
module clk_rate_monitor #(
    parameter int PERIOD_G0  = 4,
    parameter int PERIOD_G1  = 8,
    parameter int PERIOD_G2  = 16,
    parameter int TOL        = 1,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             i_local_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [1:0]       i_gen_speed,
    input  logic             i_mon_clk,
    output logic             o_locked,
    output logic             o_rate_err,
    output logic             o_stuck,
    output logic [CNT_W-1:0] o_meas_period,
    output logic             o_period_valid
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_TRACK   = 2'd2;
    localparam logic [1:0] S_LOCKED  = 2'd3;

    // Two spare bits so exp+TOL and 4*exp never overflow the comparison width.
    localparam int EW   = CNT_W + 2;
    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_edge_q;
    logic [1:0]       r_gen_speed;
    logic [CNT_W-1:0] r_cnt;
    logic [MC_W-1:0]  r_match_cnt;
    logic [1:0]       r_state;
    logic             r_locked;
    logic             r_rate_err;
    logic             r_stuck;
    logic [CNT_W-1:0] r_meas;
    logic             r_valid;

    logic             w_rise;
    logic [EW-1:0]    w_exp;
    logic [EW-1:0]    w_timeout_lim;
    logic [EW-1:0]    w_cnt_ext;
    logic             w_match;
    logic             w_speed_chg;
    logic             w_timeout;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_state_nxt;
    logic [MC_W-1:0]  w_mc_nxt;
    logic             w_rate_err_nxt;
    logic             w_stuck_nxt;
    logic             w_valid_nxt;
    logic [CNT_W-1:0] w_meas_nxt;

    assign w_rise = r_sync2 & ~r_edge_q;

    always_comb begin
        case (r_gen_speed)
            2'd1:    w_exp = EW'(PERIOD_G1);
            2'd2:    w_exp = EW'(PERIOD_G2);
            default: w_exp = EW'(PERIOD_G0);
        endcase
    end

    assign w_timeout_lim = w_exp << 2;
    assign w_cnt_ext     = EW'(r_cnt);
    assign w_match       = (w_cnt_ext <= w_exp + EW'(TOL)) &&
                           (w_cnt_ext + EW'(TOL) >= w_exp);
    assign w_speed_chg   = (i_gen_speed != r_gen_speed);
    assign w_timeout     = !w_rise && (w_cnt_ext >= w_timeout_lim);

    // Counter restarts at 1 on every rise so it always holds cycles elapsed since that rise.
    always_comb begin
        if (w_rise) begin
            w_cnt_nxt = CNT_W'(1);
        end else if (r_cnt == CNT_MAX) begin
            w_cnt_nxt = r_cnt;
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_mc_nxt       = r_match_cnt;
        w_rate_err_nxt = 1'b0;
        w_stuck_nxt    = 1'b0;
        w_valid_nxt    = 1'b0;
        w_meas_nxt     = r_meas;

        if (!i_enable) begin
            w_state_nxt = S_IDLE;
            w_mc_nxt    = '0;
        end else if (w_speed_chg) begin
            w_state_nxt = S_ACQUIRE;
            w_mc_nxt    = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ACQUIRE;
                end
                S_ACQUIRE: begin
                    if (w_rise) begin
                        w_state_nxt = S_TRACK;
                        w_mc_nxt    = '0;
                    end
                end
                S_TRACK, S_LOCKED: begin
                    if (w_timeout) begin
                        w_stuck_nxt = 1'b1;
                        w_state_nxt = S_ACQUIRE;
                        w_mc_nxt    = '0;
                    end else if (w_rise) begin
                        w_meas_nxt  = r_cnt;
                        w_valid_nxt = 1'b1;
                        if (w_match) begin
                            if (r_state == S_TRACK) begin
                                w_mc_nxt = r_match_cnt + MC_W'(1);
                                if (r_match_cnt + MC_W'(1) == MC_W'(LOCK_COUNT)) begin
                                    w_state_nxt = S_LOCKED;
                                end
                            end
                        end else begin
                            w_rate_err_nxt = 1'b1;
                            w_mc_nxt       = '0;
                            w_state_nxt    = S_TRACK;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_mc_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_local_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_edge_q    <= 1'b0;
            r_gen_speed <= 2'd0;
            r_cnt       <= '0;
            r_match_cnt <= '0;
            r_state     <= S_IDLE;
            r_locked    <= 1'b0;
            r_rate_err  <= 1'b0;
            r_stuck     <= 1'b0;
            r_meas      <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_sync1     <= i_mon_clk;
            r_sync2     <= r_sync1;
            r_edge_q    <= r_sync2;
            r_gen_speed <= i_gen_speed;
            r_cnt       <= w_cnt_nxt;
            r_match_cnt <= w_mc_nxt;
            r_state     <= w_state_nxt;
            r_locked    <= (w_state_nxt == S_LOCKED);
            r_rate_err  <= w_rate_err_nxt;
            r_stuck     <= w_stuck_nxt;
            r_meas      <= w_meas_nxt;
            r_valid     <= w_valid_nxt;
        end
    end

    assign o_locked       = r_locked;
    assign o_rate_err     = r_rate_err;
    assign o_stuck        = r_stuck;
    assign o_meas_period  = r_meas;
    assign o_period_valid = r_valid;

endmodule
